// File: rtl/audio_sample_fifo.sv
// Sample FIFO and sample-rate strobe generator that feeds the sigma-delta DAC.
// Define AUDIO_FIFO_IRQ_EN to add the registered low-water / underrun irq output.
//
// Push handshake: a word is accepted on any clk edge where wr_valid && wr_ready.
// wr_ready is held low during reset and whenever the FIFO is full.
// There is no combinational path from wr_valid to wr_ready.
module audio_sample_fifo #(
    parameter int BITDEPTH        = 12,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int DIV_WIDTH       = 16,
    parameter int LOW_WATER       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [DIV_WIDTH-1:0]       divider,
    input  logic [BITDEPTH-1:0]        wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [FIFO_DEPTH_LOG2:0]   level,
    output logic                       underrun,
    input  logic                       underrun_clr,
    output logic [BITDEPTH-1:0]        pcm,
    output logic                       sample_clock
`ifdef AUDIO_FIFO_IRQ_EN
    ,
    output logic                       irq
`endif
);

    localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam logic [LVL_W-1:0]     FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [BITDEPTH-1:0]  MIDSCALE   = BITDEPTH'(1) << (BITDEPTH - 1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV    = DIV_WIDTH'(3);

    logic [BITDEPTH-1:0]        mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] cur_div;
    logic [DIV_WIDTH-1:0] eff_div;
    logic                 tick_d;

    logic full;
    logic empty;
    logic push;
    logic tick;
    logic pop;
    logic sc_clear;

    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    assign wr_ready = rst_n && !full;
    assign push     = wr_valid && wr_ready;
    assign tick     = enable && (cnt == '0);
    assign pop      = tick && !empty;
    assign eff_div  = (divider < MIN_DIV) ? MIN_DIV : divider;

    // Low phase starts on the edge where the counter lands on half the period
    // latched at the last reload, so a mid-period divider change cannot glitch it.
    assign sc_clear = (cnt != '0) && ((cnt - DIV_WIDTH'(1)) == (cur_div >> 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            cur_div <= MIN_DIV;
            tick_d  <= 1'b0;
        end else if (!enable) begin
            cnt    <= '0;
            tick_d <= 1'b0;
        end else begin
            tick_d <= tick;
            if (tick) begin
                cnt     <= eff_div;
                cur_div <= eff_div;
            end else begin
                cnt <= cnt - DIV_WIDTH'(1);
            end
        end
    end

    // sample_clock rises one edge after pcm is updated, giving the DAC a full
    // clk of setup on the held sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_clock <= 1'b0;
        end else if (!enable) begin
            sample_clock <= 1'b0;
        end else if (tick_d) begin
            sample_clock <= 1'b1;
        end else if (sc_clear) begin
            sample_clock <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcm      <= MIDSCALE;
            underrun <= 1'b0;
        end else begin
            if (pop) begin
                pcm <= mem[rd_ptr];
            end
            if (tick && empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

`ifdef AUDIO_FIFO_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= enable && ((level <= LVL_W'(LOW_WATER)) || underrun);
        end
    end
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: directed test-plan steps then random
// traffic, all checked each cycle against a queue-and-timestamp reference model.
module tb_audio_sample_fifo;

    localparam int BITDEPTH        = 12;
    localparam int FIFO_DEPTH_LOG2 = 4;
    localparam int DIV_WIDTH       = 16;
    localparam int LOW_WATER       = 4;
    localparam int DEPTH           = 2 ** FIFO_DEPTH_LOG2;
    localparam logic [BITDEPTH-1:0] MID = 12'h800;

    logic                     clk;
    logic                     rst_n;
    logic                     enable;
    logic [DIV_WIDTH-1:0]     divider;
    logic [BITDEPTH-1:0]      wr_data;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [FIFO_DEPTH_LOG2:0] level;
    logic                     underrun;
    logic                     underrun_clr;
    logic [BITDEPTH-1:0]      pcm;
    logic                     sample_clock;
`ifdef AUDIO_FIFO_IRQ_EN
    logic                     irq;
`endif

    audio_sample_fifo #(
        .BITDEPTH(BITDEPTH),
        .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2),
        .DIV_WIDTH(DIV_WIDTH),
        .LOW_WATER(LOW_WATER)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .divider(divider),
        .wr_data(wr_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .level(level),
        .underrun(underrun),
        .underrun_clr(underrun_clr),
        .pcm(pcm),
        .sample_clock(sample_clock)
`ifdef AUDIO_FIFO_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state: queue contents plus tick timestamps in edge numbers
    logic [BITDEPTH-1:0] q[$];
    logic [BITDEPTH-1:0] m_pcm;
    logic                m_und;
    logic                m_sc;
    logic                m_irq;
    int                  k;
    int                  next_tick;
    int                  sc_start;
    int                  sc_end;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, k);
        end
    endtask

    // advance one clk edge: update the model from the pre-edge inputs, then compare
    task automatic step();
        int  size_before;
        logic und_before;
        logic tick;
        int  eff;
        size_before = q.size();
        und_before  = m_und;
        tick        = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_pcm     = MID;
            m_und     = 1'b0;
            m_irq     = 1'b0;
            next_tick = k + 1;
            sc_start  = 0;
            sc_end    = 0;
        end else begin
            m_irq = enable && ((size_before <= LOW_WATER) || und_before);
            if (!enable) begin
                next_tick = k + 1;
                sc_end    = 0;
            end else begin
                tick = (k == next_tick);
            end
            if (tick) begin
                if (size_before > 0) m_pcm = q.pop_front();
                else m_und = 1'b1;
                eff       = (divider < 3) ? 3 : int'(divider);
                next_tick = k + eff + 1;
                sc_start  = k + 1;
                sc_end    = k + eff - (eff >> 1);
            end
            if (!(tick && size_before == 0) && underrun_clr) m_und = 1'b0;
            if (wr_valid && size_before < DEPTH) q.push_back(wr_data);
        end
        m_sc = rst_n && enable && (k >= sc_start) && (k < sc_end);
        @(posedge clk);
        #1;
        k++;
        check("level", 32'(level), 32'(q.size()));
        check("pcm", 32'(pcm), 32'(m_pcm));
        check("underrun", 32'(underrun), 32'(m_und));
        check("sample_clock", 32'(sample_clock), 32'(m_sc));
        check("wr_ready", 32'(wr_ready), 32'(rst_n && q.size() < DEPTH));
`ifdef AUDIO_FIFO_IRQ_EN
        check("irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    // driver tasks
    task automatic push_word(input logic [BITDEPTH-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        k = 0; next_tick = 1; sc_start = 0; sc_end = 0;
        m_pcm = MID; m_und = 1'b0; m_sc = 1'b0; m_irq = 1'b0;
        rst_n = 1'b0; enable = 1'b0; divider = 16'd9;
        wr_data = '0; wr_valid = 1'b0; underrun_clr = 1'b0;

        // reset state
        idle(2);
        check("reset_pcm", 32'(pcm), 32'(MID));
        check("reset_wr_ready", 32'(wr_ready), 32'd0);
        rst_n = 1'b1;
        step();

        // idle pushes do not play
        push_word(12'h100);
        push_word(12'h200);
        push_word(12'h300);
        idle(2);
        check("plan_level3", 32'(level), 32'd3);
        check("plan_pcm_idle", 32'(pcm), 32'(MID));

        // playback at divider 9: first tick on first enabled edge
        enable = 1'b1;
        step();
        check("plan_first_pcm", 32'(pcm), 32'h100);
        idle(9);
        check("plan_pcm_hold", 32'(pcm), 32'h100);
        step();
        check("plan_second_pcm", 32'(pcm), 32'h200);
        idle(12);

        // fill to full while idle, extra pushes are refused
        enable = 1'b0;
        step();
        for (int i = 0; i < DEPTH + 2; i++) push_word(12'($urandom));
        check("plan_full_level", 32'(level), 32'(DEPTH));
        check("plan_full_ready", 32'(wr_ready), 32'd0);
        enable = 1'b1;
        divider = 16'd3;
        wr_valid = 1'b1;
        wr_data = 12'hABC;
        step();
        wr_valid = 1'b0;
        check("plan_pop_when_full", 32'(level), 32'(DEPTH - 1));

        // drain into underrun, clear it, watch it return
        idle(4 * DEPTH + 6);
        check("plan_underrun", 32'(underrun), 32'd1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        idle(6);

        // clamped divider then reset mid-playback
        divider = 16'd1;
        for (int i = 0; i < 7; i++) push_word(12'($urandom));
        idle(5);
        rst_n = 1'b0;
        wr_valid = 1'b1;
        idle(2);
        check("plan_reset_level", 32'(level), 32'd0);
        wr_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) enable = ~enable;
            if ($urandom_range(0, 99) < 2) divider = 16'($urandom_range(0, 12));
            wr_valid     = ($urandom_range(0, 99) < 30);
            wr_data      = 12'($urandom);
            underrun_clr = ($urandom_range(0, 99) < 5);
            rst_n        = ($urandom_range(0, 999) >= 3);
            step();
        end
        rst_n = 1'b1;
        wr_valid = 1'b0;
        underrun_clr = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
